// File: rtl/user_input_conditioner_pkg.sv
// Shared button definitions, default timing and hold-FSM state type
// used by the button front end.
package user_input_conditioner_pkg;

    localparam int BTN_LEFT    = 0;
    localparam int BTN_RIGHT   = 1;
    localparam int BTN_RESTART = 2;
    localparam int BTN_DROP    = 3;
    localparam int BTN_COUNT   = 4;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_HELD,
        HOLD_REPEAT
    } hold_state_t;

    // Isolates the lowest set bit, so a chord reports only its lowest button.
    function automatic logic [BTN_COUNT-1:0] lowest_onehot(input logic [BTN_COUNT-1:0] v);
        return v & (~v + BTN_COUNT'(1));
    endfunction

endpackage

// File: rtl/user_input_conditioner_btn_channel.sv
// One button channel: 2-FF synchroniser, debouncer and hold FSM producing
// registered press / long-press / auto-repeat pulses.
module m_btn_channel
    import user_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic btn,
    output logic stable,
    output logic press,
    output logic long_pulse
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [DW-1:0] dcnt;

    hold_state_t   state;
    hold_state_t   state_nxt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic          long_done;
    logic          long_done_nxt;
    logic          press_nxt;
    logic          long_nxt;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            stable  <= 1'b0;
            dcnt    <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            if (sync_q2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == D_LAST) begin
                stable <= sync_q2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state      <= HOLD_IDLE;
            hcnt       <= '0;
            long_done  <= 1'b0;
            press      <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            long_done  <= long_done_nxt;
            press      <= press_nxt;
            long_pulse <= long_nxt;
        end
    end

    // Without auto-repeat, long_done parks HELD at the terminal count so the
    // equality compare cannot fire a second long pulse.
    always_comb begin
        state_nxt     = state;
        hcnt_nxt      = hcnt;
        long_done_nxt = long_done;
        press_nxt     = 1'b0;
        long_nxt      = 1'b0;
        unique case (state)
            HOLD_IDLE: begin
                if (stable) begin
                    state_nxt     = HOLD_HELD;
                    hcnt_nxt      = '0;
                    long_done_nxt = 1'b0;
                    press_nxt     = 1'b1;
                end
            end
            HOLD_HELD: begin
                if (!stable) begin
                    state_nxt     = HOLD_IDLE;
                    hcnt_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else if (!long_done) begin
                    if (hcnt == L_LAST) begin
                        long_nxt = 1'b1;
                        if (REPEAT_EN) begin
                            state_nxt = HOLD_REPEAT;
                            hcnt_nxt  = '0;
                        end else begin
                            long_done_nxt = 1'b1;
                        end
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            HOLD_REPEAT: begin
                if (!stable) begin
                    state_nxt     = HOLD_IDLE;
                    hcnt_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else if (hcnt == R_LAST) begin
                    press_nxt = 1'b1;
                    hcnt_nxt  = '0;
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                end
            end
            default: begin
                state_nxt     = HOLD_IDLE;
                hcnt_nxt      = '0;
                long_done_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/user_input_conditioner.sv
// Button path front end: one conditioning channel per board button, plus the
// lowest-index priority code for the game core and a busy flag.
module user_input_conditioner
    import user_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic [BTN_COUNT-1:0] i_btn,
    output logic [BTN_COUNT-1:0] o_user_input,
    output logic [BTN_COUNT-1:0] o_press,
    output logic [BTN_COUNT-1:0] o_long,
    output logic                 o_busy
);

    logic [BTN_COUNT-1:0] stable;

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
        m_btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_chan (
            .w_clk      (w_clk),
            .w_rst      (w_rst),
            .btn        (i_btn[g]),
            .stable     (stable[g]),
            .press      (o_press[g]),
            .long_pulse (o_long[g])
        );
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            o_user_input <= '0;
            o_busy       <= 1'b0;
        end else begin
            o_user_input <= lowest_onehot(stable);
            o_busy       <= |stable;
        end
    end

endmodule

// File: tb/tb_user_input_conditioner.sv
// Self-checking bench for user_input_conditioner: directed scenarios and random
// button activity compared cycle by cycle against a timestamp-based model.
module tb_user_input_conditioner;
    import user_input_conditioner_pkg::*;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned R = 8;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b1;
    logic [3:0] i_btn = 4'b0000;
    logic [3:0] o_user_input;
    logic [3:0] o_press;
    logic [3:0] o_long;
    logic       o_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc   = 0;

    // Model: debounced levels, disagreement run lengths, raw history, press timestamps.
    logic [3:0] m_stb;
    logic [3:0] raw_d1;
    logic [3:0] raw_d2;
    int         m_run [4];
    bit         m_held[4];
    int         m_t0  [4];
    int         press_cnt[4];
    int         long_cnt [4];

    always #5 w_clk = ~w_clk;

    user_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R),
        .REPEAT_EN       (1'b1)
    ) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .i_btn        (i_btn),
        .o_user_input (o_user_input),
        .o_press      (o_press),
        .o_long       (o_long),
        .o_busy       (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] lowest_ref(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_stb  = '0;
        raw_d1 = '0;
        raw_d2 = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
            m_t0[i]   = 0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            long_cnt[i]  = 0;
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic [3:0] b);
        logic [3:0] e_press;
        logic [3:0] e_long;
        int         age;
        @(negedge w_clk);
        i_btn = b;
        @(posedge w_clk);
        #1;
        cyc++;
        e_press = '0;
        e_long  = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_stb[i]) begin
                if (!m_held[i]) begin
                    m_held[i]  = 1;
                    m_t0[i]    = cyc;
                    e_press[i] = 1'b1;
                end else begin
                    age = cyc - m_t0[i];
                    if (age == int'(L))
                        e_long[i] = 1'b1;
                    else if (age > int'(L) && ((age - int'(L)) % int'(R)) == 0)
                        e_press[i] = 1'b1;
                end
            end else begin
                m_held[i] = 0;
            end
        end
        chk("user_input", o_user_input, lowest_ref(m_stb));
        chk("busy", o_busy, |m_stb);
        chk("press", o_press, e_press);
        chk("long", o_long, e_long);
        for (int i = 0; i < 4; i++) begin
            if (o_press[i]) press_cnt[i]++;
            if (o_long[i])  long_cnt[i]++;
        end
        // Debounced level flips after D consecutive edges that see the other level.
        for (int i = 0; i < 4; i++) begin
            if (raw_d2[i] == m_stb[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == int'(D)) begin
                    m_stb[i] = raw_d2[i];
                    m_run[i] = 0;
                end
            end
        end
        raw_d2 = raw_d1;
        raw_d1 = b;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) cycle(b);
    endtask

    // Asserted between edges; released 1 unit after a rising edge so the next
    // modelled edge is the first one out of reset.
    task automatic async_reset();
        #3;
        w_rst = 1'b0;
        #1;
        chk("rst_user_input", o_user_input, 4'b0000);
        chk("rst_press", o_press, 4'b0000);
        chk("rst_long", o_long, 4'b0000);
        chk("rst_busy", o_busy, 1'b0);
        model_reset();
        repeat (2) @(posedge w_clk);
        #1;
        w_rst = 1'b1;
    endtask

    initial begin
        logic [3:0] b;
        int         len;

        model_reset();
        clear_counts();
        #2;
        w_rst = 1'b0;
        #1;
        chk("init_user_input", o_user_input, 4'b0000);
        chk("init_press", o_press, 4'b0000);
        chk("init_long", o_long, 4'b0000);
        chk("init_busy", o_busy, 1'b0);
        repeat (2) @(posedge w_clk);
        #1;
        w_rst = 1'b1;

        hold(4'b0000, 3);

        // Single press on left, seen 7 cycles after it is first sampled
        hold(4'b0001, 10);
        hold(4'b0000, 12);

        // Bounce on right: runs of 1, 2, 3 cycles, then stable high
        clear_counts();
        hold(4'b0010, 1); hold(4'b0000, 1);
        hold(4'b0010, 2); hold(4'b0000, 2);
        hold(4'b0010, 3); hold(4'b0000, 3);
        hold(4'b0010, 20);
        hold(4'b0000, 12);
        chk("bounce_press_cnt", press_cnt[BTN_RIGHT], 1);

        // Long press on drop: press, long, repeats at +8 and +16
        clear_counts();
        hold(4'b1000, 44);
        hold(4'b0000, 20);
        chk("long_press_cnt", press_cnt[BTN_DROP], 3);
        chk("long_long_cnt", long_cnt[BTN_DROP], 1);

        // Short press on restart: no long pulse
        clear_counts();
        hold(4'b0100, 17);
        hold(4'b0000, 12);
        chk("short_long_cnt", long_cnt[BTN_RESTART], 0);
        chk("short_press_cnt", press_cnt[BTN_RESTART], 1);

        // Chord, then release of left only
        hold(4'b0011, 20);
        hold(4'b0010, 15);
        hold(4'b0000, 12);

        // Reset in repeat phase with the button still held afterwards
        hold(4'b0001, 40);
        async_reset();
        clear_counts();
        hold(4'b0001, 35);
        hold(4'b0000, 12);
        chk("post_rst_press_cnt", press_cnt[BTN_LEFT], 2);
        chk("post_rst_long_cnt", long_cnt[BTN_LEFT], 1);

        // Random activity, including short glitches and occasional resets
        for (int s = 0; s < 90; s++) begin
            b   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
            hold(b, len);
            if ($urandom_range(0, 29) == 0) async_reset();
        end
        hold(4'b0000, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
